// File: rtl/tb_boot_seq_pkg.sv
// Shared types and constants for the boot/run sequencer.
package tb_boot_seq_pkg;

   typedef enum logic [2:0] {
      HOLD    = 3'd0,
      LOAD    = 3'd1,
      RUN     = 3'd2,
      PASS    = 3'd3,
      FAIL    = 3'd4,
      TIMEOUT = 3'd5
   } state_e;

   // Exit code reported when the firmware load never completes; sliced to CNT_W (<= 64).
   localparam logic [63:0] EXIT_LOAD_TIMEOUT = '1;

   function automatic logic is_terminal(state_e s);
      return (s == PASS) || (s == FAIL) || (s == TIMEOUT);
   endfunction

endpackage

// File: rtl/tb_sat_counter.sv
// Clear/enable up-counter that sticks at all-ones instead of wrapping.
module tb_sat_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr,
   input  logic         en,
   output logic [W-1:0] cnt
);

   // Count register: clear has priority, increment stops at all-ones.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en && (cnt != {W{1'b1}})) begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/tb_boot_sequencer.sv
// Run-control sequencer for the x-heep test harness: holds the SoC in reset,
// latches boot straps, requests the JTAG firmware load, then times the run and
// classifies the exit as pass, fail or timeout.
// Build option: define TB_BOOT_SEQ_WATCHDOG_EN to enable the maxcycles_i
// watchdog and the LOAD_TIMEOUT check; otherwise TIMEOUT is unreachable.
//
// state   | meaning
// HOLD    | SoC held in reset, counting RESET_WAIT_CYCLES
// LOAD    | load_req_o high, waiting for load_ack_i
// RUN     | SoC running, waiting for an exit strobe
// PASS    | exit code 0 observed (sticky)
// FAIL    | non-zero exit code or load timeout (sticky)
// TIMEOUT | watchdog expired (sticky)
module tb_boot_sequencer #(
   parameter int RESET_WAIT_CYCLES = 50,
   parameter int CNT_W             = 32,
   parameter int LOAD_TIMEOUT      = 1024,
   parameter int JTAG_DPI          = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             boot_sel_i,
   input  logic             execute_from_flash_i,
   input  logic [CNT_W-1:0] maxcycles_i,
   input  logic             load_ack_i,
   input  logic             exit_valid_i,
   input  logic [CNT_W-1:0] exit_value_i,
   output logic             soc_rst_no,
   output logic             boot_select_o,
   output logic             execute_from_flash_o,
   output logic             load_req_o,
   output logic             done_o,
   output logic             pass_o,
   output logic             timeout_o,
   output logic [CNT_W-1:0] exit_value_o,
   output logic [CNT_W-1:0] cycle_cnt_o,
   output logic [2:0]       state_o
);

   import tb_boot_seq_pkg::*;

   localparam int HOLD_W = $clog2(RESET_WAIT_CYCLES + 1);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_WAIT_CYCLES - 1);

   state_e             state_q;
   state_e             state_d;
   logic               boot_d;
   logic               eff_d;
   logic               timeout_d;
   logic [CNT_W-1:0]   exit_d;
   logic [HOLD_W-1:0]  hold_cnt;
   logic               hold_last;
   logic               wd_hit;
   logic               load_to;

   // Free-running run timer; freezes as soon as a terminal state is entered.
   tb_sat_counter #(.W(CNT_W)) u_cycle_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (1'b0),
      .en    (!is_terminal(state_d)),
      .cnt   (cycle_cnt_o)
   );

   tb_sat_counter #(.W(HOLD_W)) u_hold_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (1'b0),
      .en    (state_q == HOLD),
      .cnt   (hold_cnt)
   );

   assign hold_last = (hold_cnt == HOLD_LAST);

`ifdef TB_BOOT_SEQ_WATCHDOG_EN
   localparam int LOAD_W = (LOAD_TIMEOUT > 1) ? $clog2(LOAD_TIMEOUT + 1) : 1;
   localparam logic [LOAD_W-1:0] LOAD_LAST = LOAD_W'((LOAD_TIMEOUT > 0) ? LOAD_TIMEOUT - 1 : 0);

   logic [LOAD_W-1:0] load_cnt;

   // LOAD is entered at most once per reset, so this counter never needs clearing.
   tb_sat_counter #(.W(LOAD_W)) u_load_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (1'b0),
      .en    (state_q == LOAD),
      .cnt   (load_cnt)
   );

   assign wd_hit  = (maxcycles_i != '0) && (cycle_cnt_o >= maxcycles_i);
   assign load_to = (LOAD_TIMEOUT != 0) && (load_cnt == LOAD_LAST);
`else
   localparam int unused_load_timeout = LOAD_TIMEOUT;
   logic unused_maxcycles;

   assign unused_maxcycles = ^maxcycles_i;
   assign wd_hit           = 1'b0;
   assign load_to          = 1'b0;
`endif

   // Next-state and next-output decode; the exit strobe outranks the watchdog in RUN.
   always_comb begin
      state_d   = state_q;
      boot_d    = boot_select_o;
      eff_d     = execute_from_flash_o;
      exit_d    = exit_value_o;
      timeout_d = timeout_o;
      case (state_q)
         HOLD: begin
            if (hold_last) begin
               boot_d  = boot_sel_i;
               eff_d   = boot_sel_i & execute_from_flash_i;
               state_d = (!boot_sel_i && (JTAG_DPI == 0)) ? LOAD : RUN;
            end
         end
         LOAD: begin
            if (load_ack_i) begin
               state_d = RUN;
            end else if (load_to) begin
               state_d   = FAIL;
               exit_d    = EXIT_LOAD_TIMEOUT[CNT_W-1:0];
               timeout_d = 1'b1;
            end else if (wd_hit) begin
               state_d   = TIMEOUT;
               timeout_d = 1'b1;
            end
         end
         RUN: begin
            if (exit_valid_i) begin
               state_d = (exit_value_i == '0) ? PASS : FAIL;
               exit_d  = exit_value_i;
            end else if (wd_hit) begin
               state_d   = TIMEOUT;
               timeout_d = 1'b1;
            end
         end
         default: begin
            state_d = state_q;
         end
      endcase
   end

   // State and output registers; every output is decoded from the next state so none is combinational.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q              <= HOLD;
         soc_rst_no           <= 1'b0;
         boot_select_o        <= 1'b0;
         execute_from_flash_o <= 1'b0;
         load_req_o           <= 1'b0;
         done_o               <= 1'b0;
         pass_o               <= 1'b0;
         timeout_o            <= 1'b0;
         exit_value_o         <= '0;
      end else begin
         state_q              <= state_d;
         soc_rst_no           <= (state_d != HOLD);
         boot_select_o        <= boot_d;
         execute_from_flash_o <= eff_d;
         load_req_o           <= (state_d == LOAD);
         done_o               <= is_terminal(state_d);
         pass_o               <= (state_d == PASS);
         timeout_o            <= timeout_d;
         exit_value_o         <= exit_d;
      end
   end

   assign state_o = state_q;

endmodule
